// File: rtl/ram_sync_np_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_np_pkg
// Description : Shared types and helpers for the multi-read-port synchronous
//               RAM: clear-sequencer state encoding and a clog2 helper used to
//               derive the byte-offset and word-index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_sync_np_pkg;

    // Clear sequencer state bus: sweeping the array, or serving requests.
    typedef enum logic [0:0] {
        RAM_ST_CLEAR = 1'b0,
        RAM_ST_RUN   = 1'b1
    } ram_state_t;

    // Ceiling log2; ram_clog2(1) = 0.
    function automatic int unsigned ram_clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : ram_sync_np_pkg
`default_nettype wire

// File: rtl/ram_sync_np_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_np_if
// Description : Request/response bundle of the RAM. Ports:
//               rd_en_i/rd_addr_i   N_RD read requests (packed per port)
//               rd_data_o/rd_valid_o registered read responses
//               wr_en_i/wr_addr_i/wr_data_i/wr_sel_i  byte-masked write
//               init_busy_o         clear sweep in progress
//               master = requester side, slave = RAM side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_sync_np_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_RD       = 2
);
    logic [N_RD-1:0]            rd_en_i;
    logic [N_RD*ADDR_WIDTH-1:0] rd_addr_i;
    logic [N_RD*DATA_WIDTH-1:0] rd_data_o;
    logic [N_RD-1:0]            rd_valid_o;
    logic                       wr_en_i;
    logic [ADDR_WIDTH-1:0]      wr_addr_i;
    logic [DATA_WIDTH-1:0]      wr_data_i;
    logic [DATA_WIDTH/8-1:0]    wr_sel_i;
    logic                       init_busy_o;

    modport master (
        output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_sel_i,
        input  rd_data_o, rd_valid_o, init_busy_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_sel_i,
        output rd_data_o, rd_valid_o, init_busy_o
    );
endinterface : ram_sync_np_if
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_clear_seq
// Description : Post-reset clear sequencer. Walks the word index from 0 to
//               DEPTH-1, one word per cycle, then parks in RUN.
//               clk/rst_n      clock, asynchronous active-low reset
//               clr_we         zero-write strobe for the array (CLEAR state)
//               clr_idx        word index being cleared
//               init_busy_o    registered busy flag, low from first RUN cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ram_clear_seq
    import ram_sync_np_pkg::*;
#(
    parameter int DEPTH          = 16384,
    parameter int IDX_W          = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  clr_we,
    output logic [IDX_W-1:0]      clr_idx,
    output logic                  init_busy_o
);

    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam ram_state_t       c_RESET_STATE = CLEAR_ON_RESET ? RAM_ST_CLEAR : RAM_ST_RUN;

    ram_state_t       r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
            r_cnt   <= '0;
            r_busy  <= CLEAR_ON_RESET;
        end else begin
            case (r_state)
                RAM_ST_CLEAR: begin
                    r_cnt <= r_cnt + IDX_W'(1);
                    // The last word is zeroed on this edge; busy falls together
                    // with the state change so it is low on the first RUN cycle.
                    if (r_cnt == c_LAST_IDX) begin
                        r_state <= RAM_ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RAM_ST_RUN;
                end
            endcase
        end
    end

    assign clr_we      = (r_state == RAM_ST_CLEAR);
    assign clr_idx     = r_cnt;
    assign init_busy_o = r_busy;

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_sync_np.sv
`default_nettype none
// ============================================================================
// Module      : ram_sync_np
// Description : Synchronous RAM with N_RD registered read ports (1-cycle
//               latency, per-port valid), one byte-masked write port with
//               write-first forwarding to every read port, and a post-reset
//               clear sweep that keeps the array free of reset logic.
//               clk/rst_n   clock, asynchronous active-low reset
//               bus         ram_sync_np_if slave modport (all requests and
//                           responses, see the interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sync_np
    import ram_sync_np_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16384,
    parameter int ADDR_WIDTH     = 32,
    parameter int N_RD           = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    ram_sync_np_if.slave   bus
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int LSB   = ram_clog2(LANES);
    localparam int IDX_W = ram_clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

    // Byte-lane merge: lane k comes from new_word where sel[k] is set.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [LANES-1:0]      sel
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_word;
        for (int k = 0; k < LANES; k++) begin
            if (sel[k]) begin
                r[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [IDX_W-1:0]      w_clr_idx;
    logic                  w_user_we;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_data;
    logic [LANES-1:0]      w_mem_sel;
    logic                  w_unused_addr;

    ram_clear_seq #(
        .DEPTH          (DEPTH),
        .IDX_W          (IDX_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_we      (w_clr_we),
        .clr_idx     (w_clr_idx),
        .init_busy_o (w_busy)
    );

    assign bus.init_busy_o = w_busy;

    // Byte-offset bits and bits above the index are dropped (addresses alias).
    assign w_wr_idx      = bus.wr_addr_i[LSB +: IDX_W];
    assign w_unused_addr = ^{bus.wr_addr_i, bus.rd_addr_i};
    assign w_user_we     = bus.wr_en_i && !w_busy;

    // The sweep owns the single write port while busy; users are locked out.
    assign w_mem_we   = w_clr_we | w_user_we;
    assign w_mem_idx  = w_clr_we ? w_clr_idx : w_wr_idx;
    assign w_mem_data = w_clr_we ? ZERO_WORD : bus.wr_data_i;
    assign w_mem_sel  = w_clr_we ? {LANES{1'b1}} : bus.wr_sel_i;

    // Per-lane write enables, no reset: maps onto byte-enabled block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_mem_sel[k]) begin
                    r_mem[w_mem_idx][8*k +: 8] <= w_mem_data[8*k +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [IDX_W-1:0]      w_idx;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] r_data;
        logic                  r_valid;

        assign w_idx = bus.rd_addr_i[p*ADDR_WIDTH + LSB +: IDX_W];
        assign w_hit = w_user_we && (w_idx == w_wr_idx);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (bus.rd_en_i[p] && !w_busy) begin
                // Write-first: a same-edge write to this index is visible.
                r_data  <= w_hit ? lane_merge(r_mem[w_idx], bus.wr_data_i, bus.wr_sel_i)
                                 : r_mem[w_idx];
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end

        assign bus.rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = r_data;
        assign bus.rd_valid_o[p]                         = r_valid;
    end : g_rd

endmodule : ram_sync_np
`default_nettype wire

// File: tb/tb_ram_sync_np.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sync_np
// Description : Directed self-checking bench. dut_clr is built with a 16-word
//               array and the clear sweep; dut_nc has the sweep disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sync_np;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   cyc;

    ram_sync_np_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_RD(2)) bus0 ();
    ram_sync_np_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .N_RD(2)) bus1 ();

    ram_sync_np #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .N_RD(2), .CLEAR_ON_RESET(1'b1)
    ) dut_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    ram_sync_np #(
        .DATA_WIDTH(32), .DEPTH(16), .ADDR_WIDTH(32), .N_RD(2), .CLEAR_ON_RESET(1'b0)
    ) dut_nc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        bus0.rd_en_i   = '0;
        bus0.rd_addr_i = '0;
        bus0.wr_en_i   = 1'b0;
        bus0.wr_addr_i = '0;
        bus0.wr_data_i = '0;
        bus0.wr_sel_i  = '0;
    endtask

    task automatic wr0(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus0.wr_en_i   = 1'b1;
        bus0.wr_addr_i = addr;
        bus0.wr_data_i = data;
        bus0.wr_sel_i  = sel;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle0();
        bus1.rd_en_i   = '0;
        bus1.rd_addr_i = '0;
        bus1.wr_en_i   = 1'b0;
        bus1.wr_addr_i = '0;
        bus1.wr_data_i = '0;
        bus1.wr_sel_i  = '0;
        repeat (3) tick();

        check_vec("reset rd_data",    bus0.rd_data_o[31:0],  32'h0);
        check_vec("reset rd_valid",   {30'd0, bus0.rd_valid_o}, 32'h0);
        check_vec("reset busy clr",   {31'd0, bus0.init_busy_o}, 32'h1);
        check_vec("reset busy noclr", {31'd0, bus1.init_busy_o}, 32'h0);

        // Release reset; hammer dut_clr with writes and reads during the sweep.
        rst_n = 1'b1;
        wr0(32'h8, 32'hDEADBEEF, 4'hF);
        bus0.rd_en_i   = 2'b11;
        bus0.rd_addr_i = {32'h8, 32'h0};
        bus1.wr_en_i   = 1'b1;
        bus1.wr_addr_i = 32'h0;
        bus1.wr_data_i = 32'h5A5AA5A5;
        bus1.wr_sel_i  = 4'hF;
        cyc = 0;
        while (bus0.init_busy_o && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                bus1.wr_en_i   = 1'b0;
                bus1.rd_en_i   = 2'b01;
                bus1.rd_addr_i = {32'h0, 32'h0};
            end else if (cyc == 2) begin
                check_vec("noclr rd data",  bus1.rd_data_o[31:0], 32'h5A5AA5A5);
                check_vec("noclr rd valid", {30'd0, bus1.rd_valid_o}, 32'h1);
                bus1.rd_en_i = 2'b00;
            end else if (cyc == 8) begin
                check_vec("busy rd_valid", {30'd0, bus0.rd_valid_o}, 32'h0);
                check_vec("busy rd_data",  bus0.rd_data_o[31:0], 32'h0);
            end
        end
        check_vec("sweep cycles", cyc, 32'd16);
        idle0();

        // Every word reads zero, including the one written while busy.
        for (int i = 0; i < 16; i++) begin
            bus0.rd_en_i   = 2'b11;
            bus0.rd_addr_i = {32'(i*4 + 3), 32'(i*4)};
            tick();
            check_vec("clear rd0",   bus0.rd_data_o[31:0],  32'h0);
            check_vec("clear rd1",   bus0.rd_data_o[63:32], 32'h0);
            check_vec("clear valid", {30'd0, bus0.rd_valid_o}, 32'h3);
        end
        idle0();

        // Byte-masked writes, then aliased read.
        wr0(32'h8, 32'hAABBCCDD, 4'b1111);
        tick();
        wr0(32'h8, 32'h11223344, 4'b0101);
        tick();
        wr0(32'h8, 32'h0, 4'b0000);
        tick();
        idle0();
        bus0.rd_en_i   = 2'b11;
        bus0.rd_addr_i = {32'h48, 32'h8};
        tick();
        check_vec("mask rd 0x8",  bus0.rd_data_o[31:0],  32'hAA22CC44);
        check_vec("mask rd 0x48", bus0.rd_data_o[63:32], 32'hAA22CC44);
        idle0();

        // Write-first forwarding on both ports.
        wr0(32'hC, 32'h12345678, 4'hF);
        tick();
        wr0(32'hC, 32'hFFFFFFFF, 4'b0011);
        bus0.rd_en_i   = 2'b11;
        bus0.rd_addr_i = {32'hD, 32'hC};
        tick();
        check_vec("fwd port0", bus0.rd_data_o[31:0],  32'h1234FFFF);
        check_vec("fwd port1", bus0.rd_data_o[63:32], 32'h1234FFFF);
        bus0.wr_en_i = 1'b0;
        tick();
        check_vec("post fwd array", bus0.rd_data_o[31:0], 32'h1234FFFF);
        idle0();

        // Valid pulse and data hold on port 1.
        wr0(32'h4, 32'hCAFEF00D, 4'hF);
        tick();
        idle0();
        bus0.rd_en_i   = 2'b10;
        bus0.rd_addr_i = {32'h4, 32'h0};
        tick();
        check_vec("hold first valid", {30'd0, bus0.rd_valid_o}, 32'h2);
        check_vec("hold first data",  bus0.rd_data_o[63:32], 32'hCAFEF00D);
        bus0.rd_en_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("hold valid", {30'd0, bus0.rd_valid_o}, 32'h0);
            check_vec("hold data",  bus0.rd_data_o[63:32], 32'hCAFEF00D);
        end

        // Asynchronous reset clears outputs before any clock edge.
        bus0.rd_en_i = 2'b10;
        tick();
        idle0();
        rst_n = 1'b0;
        #1;
        check_vec("async rst data",  bus0.rd_data_o[63:32], 32'h0);
        check_vec("async rst valid", {30'd0, bus0.rd_valid_o}, 32'h0);
        check_vec("async rst busy",  {31'd0, bus0.init_busy_o}, 32'h1);
        tick();
        rst_n = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_vec("midsweep busy", {31'd0, bus0.init_busy_o}, 32'h1);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        while (bus0.init_busy_o && cyc < 40) begin
            tick();
            cyc++;
        end
        check_vec("restart sweep cycles", cyc, 32'd16);

        // Sweep after restart zeroes previously written words.
        bus0.rd_en_i   = 2'b11;
        bus0.rd_addr_i = {32'h8, 32'hC};
        tick();
        check_vec("recleared 0xC", bus0.rd_data_o[31:0],  32'h0);
        check_vec("recleared 0x8", bus0.rd_data_o[63:32], 32'h0);
        idle0();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ram_sync_np
`default_nettype wire

// File: doc/ram_sync_np.md
Name: ram_sync_np

Overview:
- Parametrised successor to the data/instruction RAM.
- N synchronous read ports with one-cycle registered latency and a valid flag per port.
- One byte-masked write port with write-first forwarding to every read port.
- A post-reset clear sequencer zeroes the array one word per cycle. This replaces the combinational reset loop, so the array maps to block RAM. Sits between the core's fetch/LSU paths and the memory bus.

Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- DEPTH, 16384, number of words; power of two.
- ADDR_WIDTH, 32, byte-address width of every port.
- N_RD, 2, number of read ports (1..4).
- CLEAR_ON_RESET, 1, 1 = sweep-clear the array after reset; 0 = contents undefined after reset, no sweep.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rd_en_i  in  N_RD  per-port read request
- rd_addr_i  in  N_RD*ADDR_WIDTH  byte addresses; port p occupies [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data_o  out  N_RD*DATA_WIDTH  registered read data, packed the same way
- rd_valid_o  out  N_RD  rd_data_o for that port is the response to the request of the previous cycle
- wr_en_i  in  1  write request
- wr_addr_i  in  ADDR_WIDTH  byte address
- wr_data_i  in  DATA_WIDTH  write data
- wr_sel_i  in  DATA_WIDTH/8  byte-lane enables; bit k covers [8k+7:8k]
- init_busy_o  out  1  clear sweep in progress; all requests are ignored

Behaviour:
- Index width and address slicing:
  - LSB = log2(DATA_WIDTH/8), IDX_W = log2(DEPTH).
  - Word index = addr[IDX_W+LSB-1:LSB].
  - Low LSB bits are ignored (no misalignment check).
  - Upper bits are ignored, so addresses alias modulo DEPTH words.
- Reset values (asserted asynchronously): rd_data_o = 0, rd_valid_o = 0, clear counter = 0.
  - init_busy_o = 1 if CLEAR_ON_RESET else 0.
  - Array contents are not touched by reset itself.
- Clear FSM, states CLEAR and RUN:
  - Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: each cycle write 0 to array[cnt], cnt++.
  - When cnt == DEPTH-1 is written, next state is RUN.
  - init_busy_o drops on the first RUN cycle, exactly DEPTH cycles after rst_n deasserts.
  - In CLEAR, rd_en_i and wr_en_i are ignored: rd_valid_o = 0, rd_data_o holds 0, no user write occurs.
  - Reset asserted mid-sweep restarts at cnt = 0.
- Read, RUN only:
  - rd_en_i[p] at edge t gives rd_data_o[p] = array[idx] and rd_valid_o[p] = 1 after edge t.
  - rd_en_i[p] = 0 gives rd_valid_o[p] = 0 next cycle; rd_data_o[p] holds its last value.
- Write, RUN only:
  - wr_en_i at edge t updates only lanes with wr_sel_i[k] = 1; other lanes keep their value.
  - wr_sel_i = 0 leaves the word unchanged.
- Read-during-write, same index, same edge (write-first):
  - Each lane k of rd_data_o = wr_sel_i[k] ? wr_data_i lane k : old lane k.
  - Applies independently on every port.
- Simultaneous reads: any number of ports may read the same or different indices in the same cycle; no conflicts or stalls.
- Latency is fixed at 1 cycle. No backpressure exists; a request is accepted every cycle in RUN.

Decomposition:
- Shared header gains:
  - `ZERO_WORD sized by DATA_WIDTH.
  - A clog2 helper macro/function for LSB and IDX_W.
  - `RamStateBus plus state constants RAM_ST_CLEAR / RAM_ST_RUN.
- One sub-module, ram_clear_seq, holds the counter, FSM and init_busy_o.
  - Outputs: clr_we, clr_idx.
  - Top level muxes clr_we/clr_idx/0 over the user write port.
- Byte-lane merge is a local function reused by write and forwarding paths.

Test Plan:
- Bench runs with DEPTH=16, N_RD=2, CLEAR_ON_RESET=1.
- Clear sweep: release rst_n.
  - init_busy_o stays 1 for 16 cycles, then 0.
  - Reads of byte addresses 0x00..0x3C all return 0x00000000 with rd_valid_o = 1 one cycle later.
  - Writes issued while busy have no effect.
- Byte-masked write:
  - Write 0xAABBCCDD to 0x8 with sel 4'b1111, then 0x11223344 with sel 4'b0101.
  - Read 0x8 returns 0xAA22CC44.
  - Read 0x48 (aliases to index 2) returns the same.
- Write-first forwarding:
  - Index 3 holds 0x12345678.
  - Same cycle: write 0xFFFFFFFF, sel 4'b0011, to 0xC; port 0 reads 0xC; port 1 reads 0xD.
  - Both ports return 0x1234FFFF next cycle.
- Valid and hold:
  - Port 1 reads 0x4, then rd_en_i[1] = 0 for 3 cycles.
  - rd_valid_o[1] pulses for one cycle; rd_data_o[1] holds its value throughout.
- Reset mid-sweep:
  - Assert rst_n at sweep cycle 7, then release.
  - rd_data_o = 0 and rd_valid_o = 0 immediately.
  - init_busy_o stays high for a full 16 cycles.
- CLEAR_ON_RESET = 0 build: init_busy_o = 0 from reset; a write then read of 0x0 returns the written data at 1-cycle latency.
